// File: rtl/video_timing_gen.sv
// Pixel-rate raster timing generator with built-in test patterns (bars, gradient, checker, solid).
// Optional VIDEO_TPG_SCROLL_EN adds a frame counter that scrolls the patterns horizontally.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter logic        HSYNC_ACTIVE = 1'b0,
   parameter logic        VSYNC_ACTIVE = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_color,
   output logic [23:0] video_data,
   output logic        video_de,
   output logic        video_hsync,
   output logic        video_vsync,
   output logic        frame_start,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT_L  = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_L  = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

   logic [11:0] h, v, h_n, v_n;
   logic [11:0] bar_cnt, bar_cnt_n;
   logic [2:0]  bar_idx, bar_idx_n;
   logic [1:0]  pat_q, pat;
   logic        first_px;
   logic        de_d, hs_d, vs_d;
   logic [7:0]  x_eff;
   logic [2:0]  idx;
   logic [23:0] pix, data_d;

`ifdef VIDEO_TPG_SCROLL_EN
   logic [7:0] frame_cnt, fc;

   // Incremented on the edge that emits frame_start; pixel (0,0) sees the new value too.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         frame_cnt <= '0;
      else if (enable && first_px)
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

   always_comb begin
      first_px = (h == '0) && (v == '0);
      pat      = first_px ? pattern_sel : pat_q;
      de_d     = (h < H_ACT_L) && (v < V_ACT_L);
      hs_d     = (h >= HS_BEG && h < HS_END) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vs_d     = (v >= VS_BEG && v < VS_END) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
`ifdef VIDEO_TPG_SCROLL_EN
      fc       = first_px ? frame_cnt + 8'd1 : frame_cnt;
      x_eff    = h[7:0] + fc;
      idx      = bar_idx + fc[7:5];
`else
      x_eff    = h[7:0];
      idx      = bar_idx;
`endif

      pix = '0;
      case (pat)
         2'd0: begin
            case (idx)
               3'd0: pix = 24'hFFFFFF;
               3'd1: pix = 24'hFFFF00;
               3'd2: pix = 24'h00FFFF;
               3'd3: pix = 24'h00FF00;
               3'd4: pix = 24'hFF00FF;
               3'd5: pix = 24'hFF0000;
               3'd6: pix = 24'h0000FF;
               3'd7: pix = 24'h000000;
            endcase
         end
         2'd1:    pix = {x_eff, v[7:0], x_eff + v[7:0]};
         2'd2:    pix = (x_eff[4] ^ v[4]) ? '1 : '0;
         default: pix = solid_color;
      endcase
      data_d = de_d ? pix : '0;

      if (h == H_LAST) begin
         h_n = '0;
         v_n = (v == V_LAST) ? '0 : v + 12'd1;
      end else begin
         h_n = h + 12'd1;
         v_n = v;
      end

      // Bar index tracks h without a divider: sub-counter restarts on every line.
      if (h == H_LAST) begin
         bar_cnt_n = '0;
         bar_idx_n = '0;
      end else if (bar_cnt == BAR_LAST) begin
         bar_cnt_n = '0;
         bar_idx_n = bar_idx + 3'd1;
      end else begin
         bar_cnt_n = bar_cnt + 12'd1;
         bar_idx_n = bar_idx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h           <= '0;
         v           <= '0;
         bar_cnt     <= '0;
         bar_idx     <= '0;
         pat_q       <= '0;
         video_data  <= '0;
         video_de    <= 1'b0;
         video_hsync <= ~HSYNC_ACTIVE;
         video_vsync <= ~VSYNC_ACTIVE;
         frame_start <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
      end else if (enable) begin
         h           <= h_n;
         v           <= v_n;
         bar_cnt     <= bar_cnt_n;
         bar_idx     <= bar_idx_n;
         if (first_px)
            pat_q <= pattern_sel;
         video_data  <= data_d;
         video_de    <= de_d;
         video_hsync <= hs_d;
         video_vsync <= vs_d;
         frame_start <= first_px;
         pixel_x     <= h;
         pixel_y     <= v;
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster (88x50 total) so whole frames fit the run.
module tb_video_timing_gen;

   localparam int unsigned HA = 64, HF = 8, HS = 12, HB = 4;
   localparam int unsigned VA = 40, VF = 3, VS = 2, VB = 5;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = '0;
   logic [23:0] solid_color = '0;
   logic [23:0] video_data;
   logic        video_de, video_hsync, video_vsync, frame_start;
   logic [11:0] pixel_x, pixel_y;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .pattern_sel(pattern_sel), .solid_color(solid_color),
      .video_data(video_data), .video_de(video_de),
      .video_hsync(video_hsync), .video_vsync(video_vsync),
      .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [23:0] data;
      logic        de, hs, vs, fs;
      logic [11:0] px, py;
   } out_t;

   typedef struct packed {
      out_t       o;
      logic [1:0] pat;
   } sb_t;

   localparam out_t RST_VAL = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0, 12'h0};

   sb_t         sbq[$];
   int unsigned n_tests = 0, n_fail = 0;
   int unsigned mh = 0, mv = 0;
   logic [1:0]  mpat = '0;
   out_t        last = RST_VAL;
   logic [1:0]  last_pat = '0;

   logic        trk = 1'b0, fs_seen = 1'b0;
   logic        prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
   int unsigned hs_run = 0, vs_run = 0, fs_gap = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic out_t dut_out();
      return {video_data, video_de, video_hsync, video_vsync, frame_start, pixel_x, pixel_y};
   endfunction

   function automatic logic [23:0] bar_color(input int unsigned b);
      case (b)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic out_t model(input int unsigned h, input int unsigned v,
                                  input logic [1:0] pat, input logic [23:0] sc);
      out_t e;
      logic [7:0] x8, y8;
      e.de   = (h < HA) && (v < VA);
      e.hs   = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
      e.vs   = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
      e.fs   = (h == 0) && (v == 0);
      e.px   = 12'(h);
      e.py   = 12'(v);
      x8     = 8'(h);
      y8     = 8'(v);
      e.data = '0;
      if (e.de) begin
         case (pat)
            2'd0: e.data = bar_color(h / (HA / 8));
            2'd1: e.data = {x8, y8, 8'(h + v)};
            2'd2: e.data = (x8[4] ^ y8[4]) ? 24'hFFFFFF : 24'h000000;
            default: e.data = sc;
         endcase
      end
      return e;
   endfunction

   task automatic spot(input sb_t x, input out_t g);
      if (x.pat == 2'd0 && (x.o.py == 12'd5 || x.o.py == 12'd30)) begin
         case (x.o.px)
            12'd0:  check("bar_x0", g.data, 24'hFFFFFF);
            12'd7:  check("bar_x7", g.data, 24'hFFFFFF);
            12'd8:  check("bar_x8", g.data, 24'hFFFF00);
            12'd16: check("bar_x16", g.data, 24'h00FFFF);
            12'd40: check("bar_x40", g.data, 24'hFF0000);
            12'd63: check("bar_x63", g.data, 24'h000000);
            12'd70: check("blank_data", g.data, 24'h000000);
            default: ;
         endcase
      end
      if (x.pat == 2'd1 && x.o.px == 12'd60 && x.o.py == 12'd30)
         check("grad_60_30", g.data, 24'h3C1E5A);
      if (x.pat == 2'd2 && x.o.px == 12'd16 && x.o.py == 12'd0)
         check("chk_16_0", g.data, 24'hFFFFFF);
      if (x.pat == 2'd2 && x.o.px == 12'd16 && x.o.py == 12'd16)
         check("chk_16_16", g.data, 24'h000000);
      if (x.pat == 2'd3 && x.o.px == 12'd10 && x.o.py == 12'd5)
         check("solid", g.data, 24'h123456);
   endtask

   task automatic track(input out_t g);
      if (trk) begin
         if (prev_hs && !g.hs) check("hs_start_x", g.px, HA + HF);
         if (!prev_hs && g.hs) check("hs_width", hs_run, HS);
         if (!prev_vs && g.vs) begin
            check("vs_width", vs_run, VS * HT);
            check("vs_rise_pos", {g.py, g.px}, {12'(VA + VF + VS), 12'd0});
         end
         if (prev_de && !g.de && g.py < VA) check("de_fall_x", g.px, HA);
         if (g.fs && fs_seen) check("frame_period", fs_gap, HT * VT);
      end
      hs_run  = g.hs ? 0 : hs_run + 1;
      vs_run  = g.vs ? 0 : vs_run + 1;
      if (g.fs) begin
         fs_gap  = 1;
         fs_seen = 1'b1;
      end else begin
         fs_gap++;
      end
      prev_hs = g.hs;
      prev_vs = g.vs;
      prev_de = g.de;
      trk     = 1'b1;
   endtask

   task automatic cycle(input logic en, input logic [1:0] ps, input logic [23:0] sc);
      sb_t  e, x;
      out_t g;
      enable      = en;
      pattern_sel = ps;
      solid_color = sc;
      if (en) begin
         if (mh == 0 && mv == 0) mpat = ps;
         e.o   = model(mh, mv, mpat, sc);
         e.pat = mpat;
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end else begin
         e.o    = last;
         e.o.fs = 1'b0;
         e.pat  = last_pat;
      end
      last     = e.o;
      last_pat = e.pat;
      sbq.push_back(e);
      @(posedge clock);
      #1;
      g = dut_out();
      x = sbq.pop_front();
      check("pix", g, x.o);
      if (en) begin
         spot(x, g);
         track(g);
      end
   endtask

   task automatic run_to(input int unsigned th, input int unsigned tv,
                         input logic [1:0] ps, input logic [23:0] sc);
      int unsigned n = 0;
      do begin
         cycle(1'b1, ps, sc);
         n++;
      end while (!(mh == th && mv == tv) && n < HT * VT + 10);
      if (!(mh == th && mv == tv)) check("run_to_timeout", n, 0);
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mpat = '0;
      last = RST_VAL; last_pat = '0;
      trk = 1'b0; fs_seen = 1'b0;
      hs_run = 0; vs_run = 0; fs_gap = 0;
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1 check("rst_async", dut_out(), RST_VAL);
      repeat (2) @(posedge clock);
      #1 check("rst_hold", dut_out(), RST_VAL);
      #2 reset_n = 1'b1;
      model_reset();

      cycle(1'b1, 2'd0, 24'h0);
      check("first_px", {frame_start, video_de, pixel_x, pixel_y}, {1'b1, 1'b1, 24'h0});
      run_to(0, 20, 2'd0, 24'h123456);
      run_to(0, 0, 2'd3, 24'h123456);
      run_to(0, 0, 2'd3, 24'h123456);
      run_to(0, 0, 2'd1, 24'h123456);
      run_to(20, 10, 2'd2, 24'h123456);

      repeat (50) cycle(1'b0, 2'd0, 24'hABCDEF);
      check("freeze_pos", {pixel_x, pixel_y}, {12'd19, 12'd10});
      cycle(1'b1, 2'd2, 24'hABCDEF);
      check("resume_pos", {pixel_x, pixel_y}, {12'd20, 12'd10});
      run_to(30, 30, 2'd2, 24'hABCDEF);

      #2 reset_n = 1'b0;
      #1 check("rst_mid_async", dut_out(), RST_VAL);
      @(posedge clock);
      #1 check("rst_mid_hold", dut_out(), RST_VAL);
      #1 reset_n = 1'b1;
      model_reset();

      cycle(1'b1, 2'd0, 24'h0);
      check("restart_px", {frame_start, video_de, pixel_x, pixel_y}, {1'b1, 1'b1, 24'h0});
      run_to(0, 0, 2'd0, 24'h0);
      cycle(1'b1, 2'd0, 24'h0);
      check("next_fs", frame_start, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
